// File: rtl/uart_pkt_pkg.sv
// Shared types for the UART packet parser: FSM states, fetch phase,
// error codes and the default start-of-frame byte.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_t;

  // FETCH: may issue a pop; WAIT: popped byte is on in_data
  typedef enum logic {
    PH_FETCH,
    PH_WAIT
  } phase_t;

  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  function automatic logic needs_byte(state_t s);
    return s != ST_DRAIN;
  endfunction

endpackage

// File: rtl/uart_pkt_parser_buf.sv
// Payload buffer: MAX_LEN x 8 register array, sync write, comb read.
// Ports: clk, reset_n, i_we/i_waddr/i_wdata write, i_raddr/o_rdata read.
module uart_pkt_parser_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [MAX_LEN];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_pkt_parser.sv
// Frames SOF,LEN,payload,CSUM from a UART RX FIFO; releases payload on
// valid/ready after the XOR checksum passes; counts good/bad frames.
// Ports: clk, reset_n; FIFO in_empty/in_rd/in_data; out_valid/ready/
// data/idx/last; frame_ok/frame_err pulses, err_code, frame_cnt, err_cnt.
// Option: UART_PKT_PARSER_TIMEOUT_EN adds an inter-byte gap timeout.
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] SOF            = SOF_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 65535,
  localparam int        IW             = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_empty,
  output logic          in_rd,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic [7:0]    frame_cnt,
  output logic [7:0]    err_cnt
);

  localparam logic [7:0] MAXL = 8'(MAX_LEN);

  state_t     r_state, w_state_nx;
  phase_t     r_phase;
  logic       r_rd, w_rd_nx;
  logic [7:0] r_len, w_len_nx;
  logic [7:0] r_idx, w_idx_nx;
  logic [7:0] r_acc, w_acc_nx;
  logic       r_ok, w_ok_nx;
  logic       r_err, w_err_nx;
  logic [1:0] r_code, w_code_nx;
  logic [7:0] r_fcnt, r_ecnt;
  logic       w_byte, w_we, w_timeout, w_last;
  logic [7:0] w_rdata;

  assign w_byte = (r_phase == PH_WAIT);
  assign w_last = (r_idx == r_len - 8'd1);

`ifdef UART_PKT_PARSER_TIMEOUT_EN
  logic [15:0] r_gap;
  logic        w_gap_run;

  assign w_gap_run = (r_state == ST_LEN) ||
                     (r_state == ST_PAYLOAD) ||
                     (r_state == ST_CSUM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap <= '0;
    end else if (!w_gap_run || w_byte) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + 16'd1;
    end
  end

  assign w_timeout = w_gap_run && (r_gap == 16'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_len_nx   = r_len;
    w_idx_nx   = r_idx;
    w_acc_nx   = r_acc;
    w_ok_nx    = 1'b0;
    w_err_nx   = 1'b0;
    w_code_nx  = r_code;
    w_we       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_byte && in_data == SOF) w_state_nx = ST_LEN;
      end
      ST_LEN: begin
        if (w_byte) begin
          w_len_nx = in_data;
          if (in_data > MAXL) begin
            w_err_nx   = 1'b1;
            w_code_nx  = ERR_LEN;
            w_state_nx = ST_IDLE;
          end else if (in_data == 8'd0) begin
            w_acc_nx   = 8'd0;
            w_state_nx = ST_CSUM;
          end else begin
            w_acc_nx   = in_data;
            w_idx_nx   = 8'd0;
            w_state_nx = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_byte) begin
          w_we     = 1'b1;
          w_acc_nx = r_acc ^ in_data;
          if (w_last) w_state_nx = ST_CSUM;
          else        w_idx_nx   = r_idx + 8'd1;
        end
      end
      ST_CSUM: begin
        if (w_byte) begin
          w_idx_nx = 8'd0;
          if (in_data != r_acc) begin
            w_err_nx   = 1'b1;
            w_code_nx  = ERR_CSUM;
            w_state_nx = ST_IDLE;
          end else if (r_len == 8'd0) begin
            w_ok_nx    = 1'b1;
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (w_last) begin
            w_ok_nx    = 1'b1;
            w_idx_nx   = 8'd0;
            w_state_nx = ST_IDLE;
          end else begin
            w_idx_nx = r_idx + 8'd1;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
`ifdef UART_PKT_PARSER_TIMEOUT_EN
    if (w_timeout) begin
      w_err_nx   = 1'b1;
      w_code_nx  = ERR_TIMEOUT;
      w_idx_nx   = 8'd0;
      w_state_nx = ST_IDLE;
    end
`endif
    // Decide the pop from the next state so a CSUM byte
    // never triggers a stray pop on the way into DRAIN.
    w_rd_nx = needs_byte(w_state_nx) && !in_empty && !r_rd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= PH_FETCH;
      r_rd    <= 1'b0;
      r_len   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= '0;
      r_fcnt  <= '0;
      r_ecnt  <= '0;
    end else begin
      r_phase <= r_rd ? PH_WAIT : PH_FETCH;
      r_rd    <= w_rd_nx;
      r_len   <= w_len_nx;
      r_idx   <= w_idx_nx;
      r_acc   <= w_acc_nx;
      r_ok    <= w_ok_nx;
      r_err   <= w_err_nx;
      r_code  <= w_code_nx;
      if (w_ok_nx)  r_fcnt <= r_fcnt + 8'd1;
      if (w_err_nx) r_ecnt <= r_ecnt + 8'd1;
    end
  end

  uart_pkt_parser_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (IW)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_we),
    .i_waddr (r_idx[IW-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_idx[IW-1:0]),
    .o_rdata (w_rdata)
  );

  assign in_rd     = r_rd;
  assign out_valid = (r_state == ST_DRAIN);
  assign out_data  = out_valid ? w_rdata : 8'd0;
  assign out_idx   = out_valid ? r_idx[IW-1:0] : '0;
  assign out_last  = out_valid && w_last;
  assign frame_ok  = r_ok;
  assign frame_err = r_err;
  assign err_code  = r_code;
  assign frame_cnt = r_fcnt;
  assign err_cnt   = r_ecnt;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: FIFO model, output monitor,
// hand-computed expected bytes, counters and error codes.
module tb_uart_pkt_parser;

`ifdef UART_PKT_PARSER_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_empty;
  logic       in_rd;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_idx;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_cnt;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  uart_pkt_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_empty  (in_empty),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  // FIFO model: dout valid the cycle after a pop
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign in_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (in_rd && rd_ptr != wr_ptr) begin
      in_data <= mem[rd_ptr % 1024];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  // monitor: {3'b0, last, idx, data} per handshake
  int ok_n  = 0;
  int err_n = 0;
  logic [15:0] rxq [$];
  logic [7:0]  expq [$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_ok)  ok_n++;
      if (frame_err) err_n++;
      if (out_valid && out_ready)
        rxq.push_back({3'b0, out_last, out_idx, out_data});
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 1024] = b;
    wr_ptr++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ev(input string tag,
                         input int ok_exp,
                         input int err_exp);
    int n;
    n = 0;
    while ((ok_n < ok_exp || err_n < err_exp) && n < 500) begin
      tick(1);
      n++;
    end
    check({tag, "_done"}, 32'(n < 500), 1);
    tick(4);
    check({tag, "_okn"}, ok_n, ok_exp);
    check({tag, "_errn"}, err_n, err_exp);
  endtask

  task automatic check_rx(input string tag);
    int sz;
    sz = expq.size();
    check({tag, "_cnt"}, rxq.size(), sz);
    for (int i = 0; i < sz; i++) begin
      if (i < rxq.size()) begin
        check({tag, "_data"}, rxq[i][7:0], expq[i]);
        check({tag, "_idx"}, rxq[i][11:8], i);
        check({tag, "_last"}, rxq[i][12], 32'(i == sz - 1));
      end
    end
  endtask

  task automatic drain_fifo(input string tag);
    int n;
    n = 0;
    while (rd_ptr != wr_ptr && n < 200) begin
      tick(1);
      n++;
    end
    check({tag, "_fifo"}, 32'(n < 200), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ok0;
    int err0;
    logic [7:0] cs;
    logic [7:0] b;

    reset_n   = 1'b0;
    out_ready = 1'b1;
    tick(3);
    check("rst_out", {in_rd, out_valid, out_data, out_idx,
                      out_last, frame_ok, frame_err, err_code}, 0);
    check("rst_cnt", {frame_cnt, err_cnt}, 0);
    reset_n = 1'b1;
    tick(2);

    // good frame
    rxq.delete();
    push(8'hA5); push(8'h03); push(8'h11);
    push(8'h22); push(8'h33); push(8'h03);
    wait_ev("good", 1, 0);
    expq = '{8'h11, 8'h22, 8'h33};
    check_rx("good");
    check("good_fcnt", frame_cnt, 1);
    check("good_ecnt", err_cnt, 0);

    // hunt + backpressure; 02^A5^7E = D9
    out_ready = 1'b0;
    rxq.delete();
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h02);
    push(8'hA5); push(8'h7E); push(8'hD9);
    n = 0;
    while (!out_valid && n < 200) begin
      tick(1);
      n++;
    end
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", out_data, 8'hA5);
      check("bp_idx", out_idx, 0);
      tick(1);
    end
    out_ready = 1'b1;
    wait_ev("bp", 2, 0);
    expq = '{8'hA5, 8'h7E};
    check_rx("bp");
    check("bp_fcnt", frame_cnt, 2);

    // bad checksum: 01^55 = 54 != 00
    rxq.delete();
    push(8'hA5); push(8'h01); push(8'h55); push(8'h00);
    wait_ev("csum", 2, 1);
    check("csum_code", err_code, 2'b10);
    check("csum_ecnt", err_cnt, 1);
    expq.delete();
    check_rx("csum");
    push(8'hA5); push(8'h01); push(8'h42); push(8'h43);
    wait_ev("after", 3, 1);
    expq = '{8'h42};
    check_rx("after");
    check("after_fcnt", frame_cnt, 3);

    // LEN too large
    rxq.delete();
    push(8'hA5); push(8'h11);
    wait_ev("len", 3, 2);
    check("len_code", err_code, 2'b01);
    check("len_ecnt", err_cnt, 2);

    // zero length
    push(8'hA5); push(8'h00); push(8'h00);
    wait_ev("zero", 4, 2);
    expq.delete();
    check_rx("zero");
    check("zero_fcnt", frame_cnt, 4);

    // full 16-byte frame
    rxq.delete();
    expq.delete();
    push(8'hA5); push(8'h10);
    cs = 8'h10;
    for (int i = 0; i < 16; i++) begin
      b = 8'h30 + 8'(i);
      push(b);
      expq.push_back(b);
      cs = cs ^ b;
    end
    push(cs);
    wait_ev("max", 5, 2);
    check_rx("max");
    check("max_fcnt", frame_cnt, 5);

    // reset mid-frame
    push(8'hA5); push(8'h04); push(8'hAA);
    drain_fifo("mid");
    tick(3);
    ok0  = ok_n;
    err0 = err_n;
    reset_n = 1'b0;
    #1;
    check("mid_out", {in_rd, out_valid, out_data, out_idx,
                      out_last, frame_ok, frame_err, err_code}, 0);
    check("mid_cnt", {frame_cnt, err_cnt}, 0);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    check("mid_okn", ok_n, ok0);
    check("mid_errn", err_n, err0);
    rxq.delete();
    push(8'hA5); push(8'h01); push(8'h42); push(8'h43);
    wait_ev("post", ok0 + 1, err0);
    expq = '{8'h42};
    check_rx("post");
    check("post_fcnt", frame_cnt, 1);

`ifdef UART_PKT_PARSER_TIMEOUT_EN
    ok0  = ok_n;
    err0 = err_n;
    push(8'hA5); push(8'h02); push(8'h11);
    wait_ev("to", ok0, err0 + 1);
    check("to_code", err_code, 2'b11);
    check("to_ecnt", err_cnt, 1);
    rxq.delete();
    push(8'hA5); push(8'h01); push(8'h42); push(8'h43);
    wait_ev("to_post", ok0 + 1, err0 + 1);
    expq = '{8'h42};
    check_rx("to_post");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
